spi_regif: RTL and testbench
============================

# spi_regif

Parametrised SPI slave to register-bus bridge, the successor to the existing `spi` block. The SPI pins are oversampled in the system clock domain rather than clocked by SCLK. The block supports all four SPI modes, configurable address and data widths, and multi-word bursts with address auto-increment. It sits between the board SPI pins and the PWM controller register file.

## Interface
Parameters:
- `ADDR_W`, 7: register address width; header length is 1+`ADDR_W` bits.
- `DATA_W`, 8: data word width.
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- `AUTO_INC`, 1: 1 = address increments after each burst word; 0 = address is fixed.

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  synchronous active-high reset.
- `spi_clk_i`  in  1  SCLK, asynchronous.
- `spi_ncs_i`  in  1  chip select, active low, asynchronous.
- `spi_mosi_i`  in  1  master data in, asynchronous.
- `spi_miso_o`  out  1  slave data out.
- `spi_miso_oe_o`  out  1  MISO output enable, high while selected.
- `b_addr_o`  out  `ADDR_W`  bus address.
- `b_data_o`  out  `DATA_W`  write data.
- `b_data_i`  in  `DATA_W`  read data, valid one cycle after `b_read_o`.
- `b_write_o`  out  1  one-cycle write strobe.
- `b_read_o`  out  1  one-cycle read strobe.

## Operation
- Input synchronisation:
  - `spi_clk_i`, `spi_ncs_i` and `spi_mosi_i` each pass through 2-flop synchronisers.
  - SCLK edges are detected from the synchronised signal.
  - The sample edge and the shift edge are selected by `CPOL`/`CPHA` per the standard SPI definition.
- Frame format, MSB first:
  - Header: R/W bit (1 = read), then `ADDR_W` address bits.
  - Then 0..N words of `DATA_W` bits each.
- States:
  - IDLE: `spi_miso_oe_o` = 0, `spi_miso_o` = 0. Synchronised ncs falling → HDR, bit counter cleared.
  - HDR: on each sample edge, shift in one bit. After 1+`ADDR_W` bits, latch the address into `b_addr_o` and go to DATA. For a read, pulse `b_read_o`.
  - DATA, write frame: after each `DATA_W` sampled bits, present the word on `b_data_o` and pulse `b_write_o` with the current `b_addr_o`. Then increment the address (if `AUTO_INC`).
  - DATA, read frame: the word latched from `b_data_i` shifts out MSB first on shift edges. At the sample edge of the last bit of each word: increment the address (if `AUTO_INC`), pulse `b_read_o` again, and latch the next word (prefetch). MOSI is ignored.
- MISO content:
  - MISO is 0 during the header and throughout write frames.
  - For CPHA=0, the first read bit is driven on `spi_miso_o` as soon as the word is latched. No shift edge precedes it.
- Address arithmetic: increment is modulo 2^`ADDR_W` (all-ones wraps to 0).
- Deselect (synchronised ncs high) in any state:
  - Next state is IDLE.
  - A partial header or word is discarded: no `b_write_o`.
  - `spi_miso_oe_o` goes low the next cycle.
  - `b_addr_o` and `b_data_o` hold their last values.
- Reset:
  - Reset forces IDLE and clears all outputs to 0.
  - If reset is released while ncs is low, the block stays in IDLE until ncs is seen high and then low again. The interrupted frame is ignored.
- Simultaneous events:
  - ncs rising in the same cycle as a final-bit sample edge: deselect wins, no strobe.
  - `b_read_o` and `b_write_o` are never high together.

## Timing
- Reset values: `spi_miso_o` = 0, `spi_miso_oe_o` = 0, `b_addr_o` = 0, `b_data_o` = 0, `b_write_o` = 0, `b_read_o` = 0.
- Requirements on SCLK and ncs:
  - SCLK high and low phases are each ≥ 4 `clk_i` cycles.
  - ncs-low to first SCLK edge is ≥ 4 cycles.
  - Last SCLK edge to ncs-high is ≥ 4 cycles.
- Pin-to-edge-detect latency: 3 cycles (2 sync + 1 detect register).
- Write: `b_write_o` is asserted 1 cycle after the detected final sample edge. `b_data_o`/`b_addr_o` are stable in that cycle. The address increments the cycle after the strobe.
- Read:
  - `b_read_o` is asserted 1 cycle after the detected final sample edge.
  - `b_data_i` is captured on the following cycle.
  - The first bit is on `spi_miso_o` ≤ 3 cycles after the detected edge, which is before the next shift edge under the phase constraint above.
- `spi_miso_o` changes only on detected shift edges or on word load.

## Test plan
- Reset, then idle with ncs high → all outputs 0; SCLK toggling with ncs high causes no strobes.
- Mode 0, defaults: write header `0x25`, data `0x22` → one `b_write_o` pulse with `b_addr_o` = `0x25`, `b_data_o` = `0x22`.
- Mode 3: read `0x10` as a 3-word burst, bus returning `0xA5`/`0x5A`/`0x3C` → `b_read_o` pulses at addresses `0x10`, `0x11`, `0x12` (prefetch pulse at `0x13`); MISO shows `A5 5A 3C`.
- `ADDR_W`=7, write burst starting at `0x7F` with data `0x01`, `0x02` → writes land at `0x7F` then `0x00`. With `AUTO_INC`=0, both land at `0x7F`.
- ncs raised after 5 data bits of a write → no `b_write_o`; `spi_miso_oe_o` low the next cycle; a following full frame works normally.
- `rst_i` pulsed mid-frame with ncs held low → remaining SCLK edges cause no strobes; the next ncs low/high/low frame writes correctly.
- `DATA_W`=16, CPHA=1: write `0xBEEF` to `0x03` → a single strobe with `b_data_o` = `0xBEEF`.

Source files
------------

// File: rtl/spi_regif.sv
// rtl/spi_regif.sv - SPI slave to register-bus bridge, pins oversampled in the clk_i domain
module spi_regif #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0,
    parameter int AUTO_INC = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_clk_i,
    input  logic              spi_ncs_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    output logic [ADDR_W-1:0] b_addr_o,
    output logic [DATA_W-1:0] b_data_o,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_write_o,
    output logic              b_read_o
);

    localparam int HDR_BITS = ADDR_W + 1;
    localparam int MAX_BITS = (HDR_BITS > DATA_W) ? HDR_BITS : DATA_W;
    localparam int CNT_W    = $clog2(MAX_BITS);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam bit SAMPLE_RISE = (CPOL == CPHA);
    localparam bit SCLK_IDLE   = (CPOL != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA
    } state_t;

    state_t state, state_nxt;

    logic sclk_s1, sclk_s2, sclk_d;
    logic ncs_s1, ncs_s2, ncs_d;
    logic mosi_s1, mosi_s2;

    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] hdr_sr;
    logic [DATA_W-2:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [ADDR_W:0]   hdr_next;
    logic [DATA_W-1:0] rx_next;
    logic              is_read;
    logic              load_q;
    logic              skip_shift;
    logic              hdr_done;
    logic              word_done;

    // ncs synchroniser resets low so a frame already in progress at reset release
    // never looks like a falling edge; ncs must first be seen high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_s1 <= SCLK_IDLE;
            sclk_s2 <= SCLK_IDLE;
            sclk_d  <= SCLK_IDLE;
            ncs_s1  <= 1'b0;
            ncs_s2  <= 1'b0;
            ncs_d   <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= spi_clk_i;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            ncs_s1  <= spi_ncs_i;
            ncs_s2  <= ncs_s1;
            ncs_d   <= ncs_s2;
            mosi_s1 <= spi_mosi_i;
            mosi_s2 <= mosi_s1;
        end
    end

    logic sclk_rise, sclk_fall, sample_edge, shift_edge, ncs_fall, deselect;

    assign sclk_rise   = sclk_s2 & ~sclk_d;
    assign sclk_fall   = ~sclk_s2 & sclk_d;
    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
    assign ncs_fall    = ncs_d & ~ncs_s2;
    assign deselect    = ncs_s2;
    assign hdr_next    = {hdr_sr, mosi_s2};
    assign rx_next     = {rx_sr, mosi_s2};

    always_comb begin
        state_nxt = state;
        hdr_done  = 1'b0;
        word_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (ncs_fall) state_nxt = S_HDR;
            end
            S_HDR: begin
                if (deselect) begin
                    state_nxt = S_IDLE;
                end else if (sample_edge && bit_cnt == HDR_LAST) begin
                    hdr_done  = 1'b1;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (deselect) begin
                    state_nxt = S_IDLE;
                end else if (sample_edge && bit_cnt == DATA_LAST) begin
                    word_done = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            bit_cnt       <= '0;
            hdr_sr        <= '0;
            rx_sr         <= '0;
            tx_sr         <= '0;
            is_read       <= 1'b0;
            load_q        <= 1'b0;
            skip_shift    <= 1'b0;
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b0;
            b_addr_o      <= '0;
            b_data_o      <= '0;
            b_write_o     <= 1'b0;
            b_read_o      <= 1'b0;
        end else begin
            state         <= state_nxt;
            b_write_o     <= 1'b0;
            b_read_o      <= 1'b0;
            load_q        <= b_read_o;
            spi_miso_oe_o <= (state_nxt != S_IDLE);

            if (b_write_o && AUTO_INC != 0) b_addr_o <= b_addr_o + 1'b1;

            if (state == S_IDLE && ncs_fall) bit_cnt <= '0;

            if (state == S_HDR && !deselect && sample_edge) begin
                hdr_sr <= hdr_next[ADDR_W-1:0];
                if (hdr_done) begin
                    bit_cnt  <= '0;
                    b_addr_o <= hdr_next[ADDR_W-1:0];
                    is_read  <= hdr_next[ADDR_W];
                    b_read_o <= hdr_next[ADDR_W];
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (state == S_DATA && !deselect) begin
                if (sample_edge) begin
                    rx_sr   <= rx_next[DATA_W-2:0];
                    bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                    if (word_done && is_read) begin
                        b_read_o <= 1'b1;
                        if (AUTO_INC != 0) b_addr_o <= b_addr_o + 1'b1;
                    end else if (word_done) begin
                        b_write_o <= 1'b1;
                        b_data_o  <= rx_next;
                    end
                end
                // In CPHA=0 the load already drove the MSB, so the shift edge right after it is dropped.
                if (shift_edge && is_read) begin
                    if (skip_shift) begin
                        skip_shift <= 1'b0;
                    end else begin
                        spi_miso_o <= tx_sr[DATA_W-1];
                        tx_sr      <= {tx_sr[DATA_W-2:0], 1'b0};
                    end
                end
                if (load_q) begin
                    if (CPHA == 0) begin
                        spi_miso_o <= b_data_i[DATA_W-1];
                        tx_sr      <= {b_data_i[DATA_W-2:0], 1'b0};
                        skip_shift <= 1'b1;
                    end else begin
                        tx_sr <= b_data_i;
                    end
                end
            end

            if (state_nxt == S_IDLE) begin
                spi_miso_o <= 1'b0;
                skip_shift <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_regif.sv
// tb/tb_spi_regif.sv - directed self-checking bench for spi_regif
module tb_spi_regif;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic [3:0] ncs = 4'hF;
    int total = 0;
    int bad = 0;
    int both = 0;

    always #5 clk = ~clk;

    logic       mi0, oe0, wr0, rd0;
    logic [6:0] a0;
    logic [7:0] d0;
    logic       mi3, oe3, wr3, rd3;
    logic [6:0] a3;
    logic [7:0] d3;
    logic [7:0] bd3 = 8'h00;
    logic       min, oen, wrn, rdn;
    logic [6:0] an;
    logic [7:0] dn;
    logic       mi16, oe16, wr16, rd16;
    logic [6:0] a16;
    logic [15:0] d16;

    spi_regif u0 (
        .clk_i(clk), .rst_i(rst), .spi_clk_i(sclk), .spi_ncs_i(ncs[0]), .spi_mosi_i(mosi),
        .spi_miso_o(mi0), .spi_miso_oe_o(oe0), .b_addr_o(a0), .b_data_o(d0),
        .b_data_i(8'h00), .b_write_o(wr0), .b_read_o(rd0)
    );

    spi_regif #(.CPOL(1), .CPHA(1)) u3 (
        .clk_i(clk), .rst_i(rst), .spi_clk_i(sclk), .spi_ncs_i(ncs[1]), .spi_mosi_i(mosi),
        .spi_miso_o(mi3), .spi_miso_oe_o(oe3), .b_addr_o(a3), .b_data_o(d3),
        .b_data_i(bd3), .b_write_o(wr3), .b_read_o(rd3)
    );

    spi_regif #(.AUTO_INC(0)) un (
        .clk_i(clk), .rst_i(rst), .spi_clk_i(sclk), .spi_ncs_i(ncs[2]), .spi_mosi_i(mosi),
        .spi_miso_o(min), .spi_miso_oe_o(oen), .b_addr_o(an), .b_data_o(dn),
        .b_data_i(8'h00), .b_write_o(wrn), .b_read_o(rdn)
    );

    spi_regif #(.DATA_W(16), .CPHA(1)) u16 (
        .clk_i(clk), .rst_i(rst), .spi_clk_i(sclk), .spi_ncs_i(ncs[3]), .spi_mosi_i(mosi),
        .spi_miso_o(mi16), .spi_miso_oe_o(oe16), .b_addr_o(a16), .b_data_o(d16),
        .b_data_i(16'h0000), .b_write_o(wr16), .b_read_o(rd16)
    );

    // Register file seen by u3: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd3) begin
            case (a3)
                7'h10:   bd3 <= 8'hA5;
                7'h11:   bd3 <= 8'h5A;
                7'h12:   bd3 <= 8'h3C;
                default: bd3 <= 8'h00;
            endcase
        end
    end

    typedef struct {
        int          id;
        logic [6:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t wq[$];
    logic [6:0] rq[$];

    always @(negedge clk) begin
        if (wr0)  wq.push_back('{id: 0, a: a0, d: {8'h00, d0}});
        if (wr3)  wq.push_back('{id: 1, a: a3, d: {8'h00, d3}});
        if (wrn)  wq.push_back('{id: 2, a: an, d: {8'h00, dn}});
        if (wr16) wq.push_back('{id: 3, a: a16, d: d16});
        if (rd3)  rq.push_back(a3);
        if ((wr0 && rd0) || (wr3 && rd3) || (wrn && rdn) || (wr16 && rd16)) both++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ncs_low(input int id);
        ncs[id] = 1'b0;
        cyc(8);
    endtask

    task automatic ncs_high(input int id);
        cyc(8);
        ncs[id] = 1'b1;
        cyc(8);
    endtask

    task automatic clock_bits(input bit cpol, input bit cpha, input logic [63:0] bits,
                              input int n, output logic [63:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi = bits[i];
                cyc(HALF);
                sclk = ~cpol;
                rx = {rx[62:0], mi3};
                cyc(HALF);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = bits[i];
                cyc(HALF);
                sclk = cpol;
                rx = {rx[62:0], mi3};
                cyc(HALF);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        total++; if (mi0 !== 1'b0) begin bad++; $display("FAIL reset_miso: got %0h want 0", mi0); end
        total++; if (oe0 !== 1'b0) begin bad++; $display("FAIL reset_oe: got %0h want 0", oe0); end
        total++; if (a0 !== 7'h00) begin bad++; $display("FAIL reset_addr: got %0h want 0", a0); end
        total++; if (d0 !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h want 0", d0); end
        total++; if (wr0 !== 1'b0) begin bad++; $display("FAIL reset_write: got %0h want 0", wr0); end
        total++; if (rd0 !== 1'b0) begin bad++; $display("FAIL reset_read: got %0h want 0", rd0); end
        rst = 1'b0;
        cyc(4);
    endtask

    task automatic test_idle();
        wq.delete();
        rq.delete();
        repeat (10) begin
            sclk = ~sclk;
            cyc(HALF);
        end
        total++; if (wq.size() !== 0) begin bad++; $display("FAIL idle_writes: got %0d want 0", wq.size()); end
        total++; if (rq.size() !== 0) begin bad++; $display("FAIL idle_reads: got %0d want 0", rq.size()); end
        total++; if (oe0 !== 1'b0) begin bad++; $display("FAIL idle_oe: got %0h want 0", oe0); end
    endtask

    task automatic test_mode0_write();
        logic [63:0] rx;
        wq.delete();
        ncs_low(0);
        clock_bits(1'b0, 1'b0, 64'h2522, 16, rx);
        ncs_high(0);
        total++; if (wq.size() !== 1) begin bad++; $display("FAIL m0_count: got %0d want 1", wq.size()); end
        if (wq.size() > 0) begin
            total++; if (wq[0].a !== 7'h25) begin bad++; $display("FAIL m0_addr: got %0h want 25", wq[0].a); end
            total++; if (wq[0].d !== 16'h0022) begin bad++; $display("FAIL m0_data: got %0h want 22", wq[0].d); end
        end
        total++; if (a0 !== 7'h26) begin bad++; $display("FAIL m0_inc: got %0h want 26", a0); end
    endtask

    task automatic test_mode3_read();
        logic [63:0] rx;
        rq.delete();
        sclk = 1'b1;
        cyc(4);
        ncs_low(1);
        clock_bits(1'b1, 1'b1, 64'h90_000000, 32, rx);
        ncs_high(1);
        sclk = 1'b0;
        cyc(4);
        total++; if (rq.size() !== 4) begin bad++; $display("FAIL m3_reads: got %0d want 4", rq.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < rq.size()) begin
                total++;
                if (rq[i] !== 7'(8'h10 + i)) begin
                    bad++; $display("FAIL m3_raddr%0d: got %0h want %0h", i, rq[i], 8'h10 + i);
                end
            end
        end
        total++; if (rx[31:24] !== 8'h00) begin bad++; $display("FAIL m3_hdr_miso: got %0h want 0", rx[31:24]); end
        total++; if (rx[23:0] !== 24'hA55A3C) begin bad++; $display("FAIL m3_miso: got %0h want a55a3c", rx[23:0]); end
    endtask

    task automatic test_wrap();
        logic [63:0] rx;
        wq.delete();
        ncs_low(0);
        clock_bits(1'b0, 1'b0, 64'h7F0102, 24, rx);
        ncs_high(0);
        total++; if (wq.size() !== 2) begin bad++; $display("FAIL wrap_count: got %0d want 2", wq.size()); end
        if (wq.size() > 1) begin
            total++; if (wq[0].a !== 7'h7F || wq[0].d !== 16'h01) begin bad++; $display("FAIL wrap_w0: got %0h/%0h want 7f/1", wq[0].a, wq[0].d); end
            total++; if (wq[1].a !== 7'h00 || wq[1].d !== 16'h02) begin bad++; $display("FAIL wrap_w1: got %0h/%0h want 0/2", wq[1].a, wq[1].d); end
        end
        wq.delete();
        ncs_low(2);
        clock_bits(1'b0, 1'b0, 64'h7F0102, 24, rx);
        ncs_high(2);
        total++; if (wq.size() !== 2) begin bad++; $display("FAIL fixed_count: got %0d want 2", wq.size()); end
        if (wq.size() > 1) begin
            total++; if (wq[0].a !== 7'h7F || wq[0].d !== 16'h01) begin bad++; $display("FAIL fixed_w0: got %0h/%0h want 7f/1", wq[0].a, wq[0].d); end
            total++; if (wq[1].a !== 7'h7F || wq[1].d !== 16'h02) begin bad++; $display("FAIL fixed_w1: got %0h/%0h want 7f/2", wq[1].a, wq[1].d); end
        end
    endtask

    task automatic test_deselect();
        logic [63:0] rx;
        wq.delete();
        ncs_low(0);
        clock_bits(1'b0, 1'b0, 64'h023F, 13, rx);
        cyc(8);
        total++; if (oe0 !== 1'b1) begin bad++; $display("FAIL dsel_oe_on: got %0h want 1", oe0); end
        ncs[0] = 1'b1;
        cyc(3);
        total++; if (oe0 !== 1'b0) begin bad++; $display("FAIL dsel_oe_off: got %0h want 0", oe0); end
        cyc(8);
        total++; if (wq.size() !== 0) begin bad++; $display("FAIL dsel_writes: got %0d want 0", wq.size()); end
        total++; if (a0 !== 7'h11) begin bad++; $display("FAIL dsel_addr_hold: got %0h want 11", a0); end
        ncs_low(0);
        clock_bits(1'b0, 1'b0, 64'h1234, 16, rx);
        ncs_high(0);
        total++; if (wq.size() !== 1) begin bad++; $display("FAIL dsel_next_count: got %0d want 1", wq.size()); end
        if (wq.size() > 0) begin
            total++; if (wq[0].a !== 7'h12 || wq[0].d !== 16'h34) begin bad++; $display("FAIL dsel_next: got %0h/%0h want 12/34", wq[0].a, wq[0].d); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] rx;
        wq.delete();
        ncs_low(0);
        clock_bits(1'b0, 1'b0, 64'h016, 10, rx);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        total++; if (a0 !== 7'h00) begin bad++; $display("FAIL rmid_addr: got %0h want 0", a0); end
        clock_bits(1'b0, 1'b0, 64'h3FFF, 14, rx);
        ncs_high(0);
        total++; if (wq.size() !== 0) begin bad++; $display("FAIL rmid_writes: got %0d want 0", wq.size()); end
        ncs_low(0);
        clock_bits(1'b0, 1'b0, 64'h4099, 16, rx);
        ncs_high(0);
        total++; if (wq.size() !== 1) begin bad++; $display("FAIL rmid_next_count: got %0d want 1", wq.size()); end
        if (wq.size() > 0) begin
            total++; if (wq[0].a !== 7'h40 || wq[0].d !== 16'h99) begin bad++; $display("FAIL rmid_next: got %0h/%0h want 40/99", wq[0].a, wq[0].d); end
        end
    endtask

    task automatic test_wide_cpha1();
        logic [63:0] rx;
        wq.delete();
        sclk = 1'b0;
        ncs_low(3);
        clock_bits(1'b0, 1'b1, 64'h03BEEF, 24, rx);
        ncs_high(3);
        total++; if (wq.size() !== 1) begin bad++; $display("FAIL w16_count: got %0d want 1", wq.size()); end
        if (wq.size() > 0) begin
            total++; if (wq[0].id !== 3) begin bad++; $display("FAIL w16_inst: got %0d want 3", wq[0].id); end
            total++; if (wq[0].a !== 7'h03) begin bad++; $display("FAIL w16_addr: got %0h want 3", wq[0].a); end
            total++; if (wq[0].d !== 16'hBEEF) begin bad++; $display("FAIL w16_data: got %0h want beef", wq[0].d); end
        end
    endtask

    task automatic test_no_overlap();
        total++; if (both !== 0) begin bad++; $display("FAIL rw_overlap: got %0d want 0", both); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_mode0_write();
        test_mode3_read();
        test_wrap();
        test_deselect();
        test_reset_mid_frame();
        test_wide_cpha1();
        test_no_overlap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
